vf_frame_sequencer: RTL and testbench

Controller between the UVC camera core's video-frame fetch interface (vf_sof/vf_req/vf_byte) and the sensor pixel stream. Tracks frame byte position, selects per frame between live source data and internal test patterns, re-aligns the source stream to frame boundaries, and substitutes fill bytes on underrun. Runs in the 60 MHz USB clock domain; the source stream arrives through an existing same-clock FIFO.

---
 rtl/vf_seq_pkg.sv | 26 ++
 rtl/vf_pattern_gen.sv | 31 +++
 rtl/vf_frame_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_vf_frame_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vf_seq_pkg.sv
// rtl/vf_seq_pkg.sv - shared mode/state encodings and CRC-8 step for the frame sequencer
package vf_seq_pkg;

    localparam logic [1:0] MODE_LIVE  = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_BARS  = 2'd2;
    localparam logic [1:0] MODE_FIXED = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // MSB-first CRC-8 over one byte
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/vf_pattern_gen.sv
// rtl/vf_pattern_gen.sv - test pattern byte (ramp / vertical bars / fixed) for the current frame position
module vf_pattern_gen
    import vf_seq_pkg::*;
#(
    parameter int FRAME_W = 252,
    parameter int BPP     = 1,
    parameter int COL_W   = 8
) (
    input  logic [1:0]       mode_i,
    input  logic [COL_W-1:0] col_i,
    input  logic [7:0]       idx_lo_i,
    input  logic [7:0]       frame_lo_i,
    input  logic [7:0]       fixed_byte_i,
    output logic [7:0]       pat_byte_o
);

    logic [2:0] bar;

    always_comb begin
        bar        = 3'(((32'(col_i) / BPP) * 8) / FRAME_W);
        pat_byte_o = 8'h00;
        case (mode_i)
            MODE_RAMP:  pat_byte_o = frame_lo_i + idx_lo_i;
            // Odd bytes of a YUY2 pair carry neutral chroma
            MODE_BARS:  pat_byte_o = (BPP == 2 && col_i[0]) ? 8'h80 : {bar, 5'b00000};
            MODE_FIXED: pat_byte_o = fixed_byte_i;
            default:    pat_byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/vf_frame_sequencer.sv
// rtl/vf_frame_sequencer.sv - frame byte sequencer between camera core fetch and source stream; VF_SEQ_CRC_EN adds per-frame CRC-8
module vf_frame_sequencer
    import vf_seq_pkg::*;
#(
    parameter int         FRAME_W   = 252,
    parameter int         FRAME_H   = 120,
    parameter int         BPP       = 1,
    parameter logic [7:0] FILL_BYTE = 8'h10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        vf_sof,
    input  logic        vf_req,
    output logic [7:0]  vf_byte,
    input  logic        src_valid,
    input  logic [7:0]  src_byte,
    input  logic        src_sof,
    output logic        src_ready,
    input  logic [1:0]  mode,
    input  logic [7:0]  fixed_byte,
    output logic [15:0] frame_cnt,
    output logic [15:0] underrun_cnt,
    output logic [7:0]  crc_out
);

    localparam int FRAME_BYTES = FRAME_W * FRAME_H * BPP;
    localparam int LINE_BYTES  = FRAME_W * BPP;
    localparam int IDX_W       = $clog2(FRAME_BYTES + 1);
    localparam int COL_W       = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam int ROW_W       = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      underrun_q, underrun_d;
    logic [7:0]       vf_byte_q, vf_byte_d;
    logic [7:0]       pat_byte;
    logic             deliver;
    logic             underrun_inc;
    logic             live_ok;

    vf_pattern_gen #(
        .FRAME_W (FRAME_W),
        .BPP     (BPP),
        .COL_W   (COL_W)
    ) u_pattern (
        .mode_i       (mode_q),
        .col_i        (col_q),
        .idx_lo_i     (8'(idx_q)),
        .frame_lo_i   (frame_cnt_q[7:0]),
        .fixed_byte_i (fixed_byte),
        .pat_byte_o   (pat_byte)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        idx_d        = idx_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_cnt_d  = frame_cnt_q;
        underrun_d   = underrun_q;
        vf_byte_d    = vf_byte_q;
        src_ready    = 1'b0;
        deliver      = 1'b0;
        underrun_inc = 1'b0;
        // A source frame start is only usable at byte 0 of our frame
        live_ok      = src_valid && !(src_sof && idx_q != '0);

        if (vf_sof) begin
            mode_d      = mode;
            frame_cnt_d = frame_cnt_q + 16'd1;
            idx_d       = '0;
            col_d       = '0;
            row_d       = '0;
            state_d     = (mode == MODE_LIVE) ? ST_SYNC : ST_ACTIVE;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    src_ready = src_valid && !src_sof;
                    if (vf_req) begin
                        vf_byte_d    = FILL_BYTE;
                        deliver      = 1'b1;
                        underrun_inc = 1'b1;
                    end else if (src_valid && src_sof && idx_q == '0) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (vf_req) begin
                        deliver = 1'b1;
                        if (mode_q == MODE_LIVE) begin
                            if (live_ok) begin
                                vf_byte_d = src_byte;
                                src_ready = 1'b1;
                            end else begin
                                vf_byte_d    = FILL_BYTE;
                                underrun_inc = 1'b1;
                                if (src_valid) state_d = ST_SYNC;
                            end
                        end else begin
                            vf_byte_d = pat_byte;
                        end
                    end
                end
                default: begin
                    if (vf_req) vf_byte_d = FILL_BYTE;
                end
            endcase

            if (deliver) begin
                idx_d = idx_q + 1'b1;
                if (col_q == COL_W'(LINE_BYTES - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                if (idx_d == IDX_W'(FRAME_BYTES)) state_d = ST_DONE;
            end

            if (underrun_inc && underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_LIVE;
            idx_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            frame_cnt_q <= 16'd0;
            underrun_q  <= 16'd0;
            vf_byte_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            col_q       <= col_d;
            row_q       <= row_d;
            frame_cnt_q <= frame_cnt_d;
            underrun_q  <= underrun_d;
            vf_byte_q   <= vf_byte_d;
        end
    end

`ifdef VF_SEQ_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic [7:0] crc_out_q, crc_out_d;

    always_comb begin
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        if (vf_sof) begin
            crc_d = 8'h00;
        end else begin
            if (deliver && state_q == ST_ACTIVE) crc_d = crc8_update(crc_q, vf_byte_d);
            if (state_d == ST_DONE && state_q != ST_DONE) crc_out_d = crc_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_q     <= 8'h00;
            crc_out_q <= 8'h00;
        end else begin
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
        end
    end

    assign crc_out = crc_out_q;
`else
    assign crc_out = 8'h00;
`endif

    assign vf_byte      = vf_byte_q;
    assign frame_cnt    = frame_cnt_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_vf_frame_sequencer.sv
// tb/tb_vf_frame_sequencer.sv - directed scoreboard bench for vf_frame_sequencer on a 4x2 MONO frame
module tb_vf_frame_sequencer;

    logic        clk;
    logic        rstn;
    logic        vf_sof;
    logic        vf_req;
    logic [7:0]  vf_byte;
    logic        src_valid;
    logic [7:0]  src_byte;
    logic        src_sof;
    logic        src_ready;
    logic [1:0]  mode;
    logic [7:0]  fixed_byte;
    logic [15:0] frame_cnt;
    logic [15:0] underrun_cnt;
    logic [7:0]  crc_out;

    int          checks;
    int          errors;
    logic        src_en;
    logic [8:0]  src_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_crc;

    vf_frame_sequencer #(
        .FRAME_W   (4),
        .FRAME_H   (2),
        .BPP       (1),
        .FILL_BYTE (8'h10)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .vf_sof       (vf_sof),
        .vf_req       (vf_req),
        .vf_byte      (vf_byte),
        .src_valid    (src_valid),
        .src_byte     (src_byte),
        .src_sof      (src_sof),
        .src_ready    (src_ready),
        .mode         (mode),
        .fixed_byte   (fixed_byte),
        .frame_cnt    (frame_cnt),
        .underrun_cnt (underrun_cnt),
        .crc_out      (crc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] crc8_model(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        if (src_en && src_q.size() > 0) begin
            src_valid = 1'b1;
            src_sof   = src_q[0][8];
            src_byte  = src_q[0][7:0];
        end else begin
            src_valid = 1'b0;
            src_sof   = 1'b0;
            src_byte  = 8'h00;
        end
    endtask

    task automatic step();
        logic took;
        @(negedge clk);
        took = src_ready;
        @(posedge clk);
        #1;
        if (took && src_q.size() > 0) void'(src_q.pop_front());
        drive_src();
    endtask

    task automatic do_req(input logic [7:0] exp);
        exp_q.push_back(exp);
        vf_req = 1'b1;
        step();
        vf_req = 1'b0;
        check("vf_byte", 16'(vf_byte), 16'(exp_q.pop_front()));
    endtask

    task automatic do_sof();
        vf_sof = 1'b1;
        step();
        vf_sof = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rstn       = 1'b0;
        vf_sof     = 1'b0;
        vf_req     = 1'b0;
        mode       = 2'd0;
        fixed_byte = 8'h00;
        src_en     = 1'b0;
        drive_src();

        #12;
        check("rst_vf_byte", 16'(vf_byte), 16'h0000);
        check("rst_frame_cnt", frame_cnt, 16'h0000);
        check("rst_underrun", underrun_cnt, 16'h0000);
        check("rst_crc", 16'(crc_out), 16'h0000);
        check("rst_src_ready", 16'(src_ready), 16'h0000);
        rstn = 1'b1;

        do_req(8'h10);
        check("idle_underrun", underrun_cnt, 16'd0);

        // ramp frame 1: frame_cnt + idx
        mode = 2'd1;
        do_sof();
        check("ramp_frame_cnt", frame_cnt, 16'd1);
        exp_crc = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            do_req(8'(i));
            exp_crc = crc8_model(exp_crc, 8'(i));
        end
        do_req(8'h10);
        check("ramp_done_underrun", underrun_cnt, 16'd0);
`ifdef VF_SEQ_CRC_EN
        check("ramp_crc", 16'(crc_out), 16'(exp_crc));
`else
        check("ramp_crc", 16'(crc_out), 16'h0000);
`endif

        // sof and req together: request ignored
        vf_sof = 1'b1;
        vf_req = 1'b1;
        step();
        vf_sof = 1'b0;
        vf_req = 1'b0;
        check("sof_req_vf_byte", 16'(vf_byte), 16'h0010);
        check("sof_req_frame_cnt", frame_cnt, 16'd2);
        do_req(8'h02);
        do_req(8'h03);

        // mode change mid-frame is ignored until next sof
        mode       = 2'd3;
        fixed_byte = 8'h5A;
        for (int i = 2; i <= 7; i++) do_req(8'(i + 2));
        do_req(8'h10);

        do_sof();
        check("fixed_frame_cnt", frame_cnt, 16'd3);
        for (int i = 0; i < 8; i++) do_req(8'h5A);
        do_req(8'h10);

        fixed_byte = 8'h00;
        do_sof();
        for (int i = 0; i < 8; i++) do_req(8'h00);
        check("zero_crc", 16'(crc_out), 16'h0000);

        // bars: 4 pixels wide -> bars 0,2,4,6
        mode = 2'd2;
        do_sof();
        for (int r = 0; r < 2; r++) begin
            do_req(8'h00);
            do_req(8'h40);
            do_req(8'h80);
            do_req(8'hC0);
        end

        // live with stale bytes ahead of the source frame start
        src_en = 1'b1;
        src_q.push_back({1'b0, 8'h11});
        src_q.push_back({1'b0, 8'h22});
        src_q.push_back({1'b0, 8'h33});
        src_q.push_back({1'b1, 8'hA0});
        for (int i = 1; i < 8; i++) src_q.push_back({1'b0, 8'(8'hA0 + i)});
        drive_src();
        check("done_src_ready", 16'(src_ready), 16'h0000);
        mode = 2'd0;
        do_sof();
        repeat (5) step();
        check("stale_dropped", 16'(src_q.size()), 16'd8);
        for (int i = 0; i < 8; i++) do_req(8'(8'hA0 + i));
        check("live_underrun", underrun_cnt, 16'd0);

        // live underrun: three requests without source data
        src_q.push_back({1'b1, 8'hB0});
        for (int i = 1; i < 8; i++) src_q.push_back({1'b0, 8'(8'hB0 + i)});
        drive_src();
        do_sof();
        step();
        do_req(8'hB0);
        do_req(8'hB1);
        src_en = 1'b0;
        drive_src();
        repeat (3) do_req(8'h10);
        check("underrun_3", underrun_cnt, 16'd3);
        src_en = 1'b1;
        drive_src();
        do_req(8'hB2);
        do_req(8'hB3);
        do_req(8'hB4);
        do_req(8'h10);
        check("underrun_after_done", underrun_cnt, 16'd3);

        // source frame start arriving mid-frame
        src_q.delete();
        src_q.push_back({1'b1, 8'hC0});
        src_q.push_back({1'b0, 8'hC1});
        src_q.push_back({1'b1, 8'hD0});
        src_q.push_back({1'b0, 8'hD1});
        drive_src();
        do_sof();
        step();
        do_req(8'hC0);
        do_req(8'hC1);
        do_req(8'h10);
        check("midsof_underrun", underrun_cnt, 16'd4);
        do_req(8'h10);
        check("resync_underrun", underrun_cnt, 16'd5);
        check("resync_src_ready", 16'(src_ready), 16'h0000);
        check("resync_head_kept", 16'(src_q.size()), 16'd2);

        // async reset in the middle of a ramp frame (frame 9)
        src_q.delete();
        drive_src();
        mode = 2'd1;
        do_sof();
        check("frame9_cnt", frame_cnt, 16'd9);
        do_req(8'h09);
        do_req(8'h0A);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_vf_byte", 16'(vf_byte), 16'h0000);
        check("arst_frame_cnt", frame_cnt, 16'h0000);
        check("arst_underrun", underrun_cnt, 16'h0000);
        check("arst_src_ready", 16'(src_ready), 16'h0000);
        #2;
        rstn = 1'b1;
        do_req(8'h10);
        check("post_rst_underrun", underrun_cnt, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
